overflow_event_reporter: RTL and testbench
==========================================

// Module: overflow_event_reporter
// PURPOSE
//   Downstream consumer of the 4-bit free-running counter stage. Watches count value and
//   sticky overflow flag; turns every wrap (all-ones -> zero) into an event record.
//   Records buffered in a small FIFO, drained by a valid/ready interface to the status/IRQ logic.
// PARAMETERS
//   CNT_W    4   width of monitored count input
//   EVT_W    8   width of saturating wrap-event counter carried in each record
//   DEPTH    4   event FIFO entries (power of two, >=2)
//   TS_W     16  timestamp width (used only with OVF_REPORT_TIMESTAMP_EN)
// PORTS
//   clk          in   1              clock, all logic on posedge
//   reset        in   1              synchronous, active-high
//   cnt_in       in   CNT_W          count value from upstream counter
//   ovf_in       in   1              sticky overflow level from upstream counter
//   evt_ready    in   1              consumer accepts record
//   evt_valid    out  1              record available
//   evt_count    out  EVT_W          wrap number of head record (1 = first wrap)
//   evt_first    out  1              head record is first wrap since ovf_in rose
//   evt_ts       out  TS_W           head record timestamp (macro only)
//   drop_flag    out  1              sticky: an event was lost to a full FIFO
//   drop_count   out  EVT_W          saturating count of lost events
//   level        out  $clog2(DEPTH)+1 FIFO occupancy
// BEHAVIOUR
//   - Reset: all outputs 0; cnt_prev<=0, ovf_prev<=0, wrap counter 0, FIFO empty.
//   - cnt_prev/ovf_prev register cnt_in/ovf_in every cycle.
//   - wrap_evt = (cnt_prev == all-ones) && (cnt_in == 0). Held counts, enable gaps, and
//     reset of upstream counter (any value -> 0 other than from all-ones) are not events.
//   - first_evt = ovf_in && !ovf_prev (rising edge). Tagged onto a wrap_evt in same cycle
//     or the next wrap_evt; one pending tag held in a 1-bit register until consumed.
//   - On wrap_evt: wrap counter +1, saturating at 2^EVT_W-1; record {new count, first tag}
//     pushed in same cycle. Latency: wrap seen cycle N -> evt_valid=1 cycle N+1 if FIFO empty.
//   - FIFO: first-word-fall-through; evt_* show head whenever evt_valid=1. Pop when
//     evt_valid && evt_ready. evt_* stable while evt_valid && !evt_ready.
//   - Full: push accepted if not full, or full with pop in same cycle. Otherwise record
//     dropped, drop_flag<=1 (sticky until reset), drop_count +1 saturating; wrap counter
//     still increments (gap in evt_count shows loss).
//   - Empty with simultaneous push: push only; no pop (evt_valid was 0).
//   - level = entries after current-cycle push/pop, registered.
//   - Reset mid-operation: FIFO contents discarded, pending first tag cleared, no event on
//     the reset cycle nor the cycle after (cnt_prev forced 0).
// CONFIGURATION
//   OVF_REPORT_TIMESTAMP_EN defined: free-running TS_W counter (reset 0, +1 per cycle,
//     wraps); value at push cycle stored with record and driven on evt_ts.
//   Undefined: no timestamp counter/storage; evt_ts port tied 0 (port kept for uniform
//     instantiation).
// STRUCTURE
//   Shared package ovf_report_pkg: evt_rec_t struct {count, first, ts}, DEPTH/width
//   defaults, saturating-increment function.
//   One sub-module: ovf_evt_fifo (FWFT, parameterised on evt_rec_t width and DEPTH,
//   push/pop/full/empty/level). Edge/wrap detect, counters, drop logic in top.
// TESTING
//   1 Drive cnt_in 0..15,0 with ovf_in rising on 15, evt_ready=1 -> one record count=1,
//     first=1, evt_valid high exactly 1 cycle after cnt_in==0 cycle.
//   2 Three wraps, evt_ready=0 -> level=3, records count 1,2,3 in order; stable while
//     stalled; then ready=1 drains 3 in 3 cycles, level 0.
//   3 DEPTH=4, ready=0, six wraps -> level=4, drop_flag=1, drop_count=2; drain shows
//     counts 1..4; next wrap record count=7.
//   4 Full FIFO, wrap coincident with pop -> push accepted, no drop, level stays 4.
//   5 cnt_in jumps 7->0 (upstream reset) and 15 held 5 cycles -> no events.
//   6 Reset asserted with 2 queued -> next cycle evt_valid=0, level=0, drop_* 0; with
//     macro, two wraps 10 cycles apart -> evt_ts delta = 10.

Source files
------------

// File: rtl/ovf_report_pkg.sv
// Shared types, default widths and helpers for the overflow event reporter.
package ovf_report_pkg;
    localparam int CNT_W_DEF = 4;
    localparam int EVT_W_DEF = 8;
    localparam int DEPTH_DEF = 4;
    localparam int TS_W_DEF  = 16;

    typedef struct packed {
        logic [EVT_W_DEF-1:0] count;
        logic                 first;
        logic [TS_W_DEF-1:0]  ts;
    } evt_rec_t;

    function automatic logic [EVT_W_DEF-1:0] sat_inc(input logic [EVT_W_DEF-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction
endpackage

// File: rtl/ovf_evt_fifo.sv
// First-word-fall-through record FIFO; a push into a full FIFO is accepted only
// when a pop happens in the same cycle.
module ovf_evt_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [W-1:0]             wdata_i,
    output logic [W-1:0]             rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   cnt_q;
    logic             push_ok, pop_ok;

    assign full_o  = (cnt_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign push_ok = push_i && (!full_o || pop_i);
    assign pop_ok  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign level_o = cnt_q;

    // When full, wr_ptr == rd_ptr: the popped slot is overwritten after it is read.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule

// File: rtl/overflow_event_reporter.sv
// Turns upstream counter wraps into queued event records drained by valid/ready.
// Define OVF_REPORT_TIMESTAMP_EN to store a free-running timestamp with each record.
module overflow_event_reporter
    import ovf_report_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int EVT_W = EVT_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int TS_W  = TS_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [CNT_W-1:0]       cnt_in,
    input  logic                   ovf_in,
    input  logic                   evt_ready,
    output logic                   evt_valid,
    output logic [EVT_W-1:0]       evt_count,
    output logic                   evt_first,
    output logic [TS_W-1:0]        evt_ts,
    output logic                   drop_flag,
    output logic [EVT_W-1:0]       drop_count,
    output logic [$clog2(DEPTH):0] level
);
`ifdef OVF_REPORT_TIMESTAMP_EN
    localparam int REC_W = EVT_W + 1 + TS_W;
`else
    localparam int REC_W = EVT_W + 1;
`endif

    logic [CNT_W-1:0] cnt_prev_q;
    logic             ovf_prev_q, first_pend_q;
    logic [EVT_W-1:0] wrap_cnt_q, wrap_cnt_d;
    logic             drop_flag_q;
    logic [EVT_W-1:0] drop_cnt_q;
    logic             wrap_evt, first_edge, tag, drop;
    logic             fifo_full, fifo_empty;
    logic [REC_W-1:0] push_data, head_data;

    assign wrap_evt   = (cnt_prev_q == {CNT_W{1'b1}}) && (cnt_in == '0);
    assign first_edge = ovf_in && !ovf_prev_q;
    assign tag        = first_edge || first_pend_q;
    assign wrap_cnt_d = wrap_evt ? sat_inc(wrap_cnt_q) : wrap_cnt_q;
    // A full FIFO frees a slot only if the head is popped this cycle.
    assign drop       = wrap_evt && fifo_full && !evt_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_prev_q   <= '0;
            ovf_prev_q   <= 1'b0;
            first_pend_q <= 1'b0;
            wrap_cnt_q   <= '0;
            drop_flag_q  <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            cnt_prev_q   <= cnt_in;
            ovf_prev_q   <= ovf_in;
            first_pend_q <= wrap_evt ? 1'b0 : tag;
            wrap_cnt_q   <= wrap_cnt_d;
            if (drop) begin
                drop_flag_q <= 1'b1;
                drop_cnt_q  <= sat_inc(drop_cnt_q);
            end
        end
    end

    ovf_evt_fifo #(.W(REC_W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (wrap_evt),
        .pop_i   (evt_ready),
        .wdata_i (push_data),
        .rdata_o (head_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level)
    );

    assign evt_valid  = !fifo_empty;
    assign drop_flag  = drop_flag_q;
    assign drop_count = drop_cnt_q;

`ifdef OVF_REPORT_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q;
    evt_rec_t        push_rec, head_rec;

    always_ff @(posedge clk) begin
        if (reset) ts_q <= '0;
        else       ts_q <= ts_q + 1'b1;
    end

    assign push_rec  = '{count: wrap_cnt_d, first: tag, ts: ts_q};
    assign push_data = push_rec;
    assign head_rec  = evt_rec_t'(head_data);
    assign evt_count = evt_valid ? head_rec.count : '0;
    assign evt_first = evt_valid && head_rec.first;
    assign evt_ts    = evt_valid ? head_rec.ts : '0;
`else
    assign push_data = {wrap_cnt_d, tag};
    assign evt_count = evt_valid ? head_data[REC_W-1:1] : '0;
    assign evt_first = evt_valid && head_data[0];
    assign evt_ts    = '0;
`endif
endmodule

// File: tb/tb_overflow_event_reporter.sv
// Directed bench for overflow_event_reporter with a queue-level reference model.
module tb_overflow_event_reporter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  cnt_in = '0;
    logic        ovf_in = 1'b0;
    logic        evt_ready = 1'b0;
    logic        evt_valid;
    logic [7:0]  evt_count;
    logic        evt_first;
    logic [15:0] evt_ts;
    logic        drop_flag;
    logic [7:0]  drop_count;
    logic [2:0]  level;

    int n_pass = 0;
    int n_total = 0;

    overflow_event_reporter dut (
        .clk        (clk),
        .reset      (reset),
        .cnt_in     (cnt_in),
        .ovf_in     (ovf_in),
        .evt_ready  (evt_ready),
        .evt_valid  (evt_valid),
        .evt_count  (evt_count),
        .evt_first  (evt_first),
        .evt_ts     (evt_ts),
        .drop_flag  (drop_flag),
        .drop_count (drop_count),
        .level      (level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act != exp)
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Reference model: records in a plain queue, rules applied per clock.
    typedef struct { int count; bit first; int ts; } rec_t;
    rec_t q[$];
    int   m_prev_cnt = 0;
    bit   m_prev_ovf = 0;
    bit   m_pend = 0;
    int   m_wraps = 0;
    bit   m_dflag = 0;
    int   m_dcnt = 0;
    int   m_ts = 0;
    bit   started = 0;

    always @(posedge clk) begin
        started = 1;
        if (reset) begin
            q.delete();
            m_prev_cnt = 0; m_prev_ovf = 0; m_pend = 0;
            m_wraps = 0; m_dflag = 0; m_dcnt = 0; m_ts = 0;
        end else begin
            bit   edge_seen, wrap, full, pop;
            rec_t r;
            edge_seen = ovf_in && !m_prev_ovf;
            wrap = (m_prev_cnt == 15) && (cnt_in == 0);
            full = (q.size() == 4);
            pop  = (q.size() > 0) && evt_ready;
            if (pop) void'(q.pop_front());
            if (wrap) begin
                m_wraps = (m_wraps < 255) ? m_wraps + 1 : 255;
                r.count = m_wraps;
                r.first = edge_seen || m_pend;
                r.ts    = m_ts;
                if (!full || pop) q.push_back(r);
                else begin
                    m_dflag = 1;
                    m_dcnt  = (m_dcnt < 255) ? m_dcnt + 1 : 255;
                end
                m_pend = 0;
            end else begin
                m_pend = m_pend || edge_seen;
            end
            m_prev_cnt = int'(cnt_in);
            m_prev_ovf = ovf_in;
            m_ts = (m_ts + 1) % 65536;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("valid", int'(evt_valid), int'(q.size() != 0));
            check("level", int'(level), q.size());
            check("drop_flag", int'(drop_flag), int'(m_dflag));
            check("drop_count", int'(drop_count), m_dcnt);
            if (q.size() != 0) begin
                check("head_count", int'(evt_count), q[0].count);
                check("head_first", int'(evt_first), int'(q[0].first));
`ifdef OVF_REPORT_TIMESTAMP_EN
                check("head_ts", int'(evt_ts), q[0].ts);
`endif
            end
`ifndef OVF_REPORT_TIMESTAMP_EN
            check("ts_tied", int'(evt_ts), 0);
`endif
        end
    end

    task automatic step(input int c, input bit o, input bit r);
        cnt_in    = 4'(c);
        ovf_in    = o;
        evt_ready = r;
        @(negedge clk);
    endtask

    task automatic wrap(input bit o, input bit r);
        step(15, o, r);
        step(0, o, r);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(0, 0, 0);
        step(0, 0, 0);
        reset = 1'b0;
    endtask

    initial begin
        int t1;
        do_reset();
        check("rst_valid", int'(evt_valid), 0);
        check("rst_level", int'(level), 0);

        // 1: single wrap with ovf rising on 15
        for (int i = 0; i < 15; i++) step(i, 0, 1);
        step(15, 1, 1);
        check("t1_pre_valid", int'(evt_valid), 0);
        step(0, 1, 1);
        check("t1_valid", int'(evt_valid), 1);
        check("t1_count", int'(evt_count), 1);
        check("t1_first", int'(evt_first), 1);
        step(0, 1, 1);
        check("t1_valid_gone", int'(evt_valid), 0);

        // 2: three stalled wraps, then drain
        do_reset();
        for (int i = 0; i < 3; i++) wrap(0, 0);
        check("t2_level", int'(level), 3);
        step(0, 0, 0);
        step(0, 0, 0);
        check("t2_stable", int'(evt_count), 1);
        for (int i = 1; i <= 3; i++) begin
            check("t2_drain", int'(evt_count), i);
            step(0, 0, 1);
        end
        check("t2_level0", int'(level), 0);

        // 3: overflow the FIFO
        do_reset();
        for (int i = 0; i < 6; i++) wrap(0, 0);
        check("t3_level", int'(level), 4);
        check("t3_dflag", int'(drop_flag), 1);
        check("t3_dcnt", int'(drop_count), 2);
        for (int i = 1; i <= 4; i++) begin
            check("t3_drain", int'(evt_count), i);
            step(0, 0, 1);
        end
        wrap(0, 1);
        check("t3_after_gap", int'(evt_count), 7);

        // 4: full FIFO, wrap coincident with pop
        do_reset();
        for (int i = 0; i < 4; i++) wrap(0, 0);
        step(15, 0, 0);
        step(0, 0, 1);
        check("t4_level", int'(level), 4);
        check("t4_nodrop", int'(drop_flag), 0);
        check("t4_head", int'(evt_count), 2);

        // 5: upstream reset jump and held all-ones are not wraps
        do_reset();
        for (int i = 0; i < 8; i++) step(i, 0, 0);
        step(0, 0, 0);
        for (int i = 0; i < 5; i++) step(15, 0, 0);
        step(1, 0, 0);
        check("t5_level", int'(level), 0);
        wrap(0, 0);
        check("t5_first_count", int'(evt_count), 1);

        // 6: reset mid-operation, then timestamp spacing
        do_reset();
        wrap(0, 0);
        wrap(0, 0);
        check("t6_level2", int'(level), 2);
        reset = 1'b1;
        step(15, 1, 0);
        check("t6_valid", int'(evt_valid), 0);
        check("t6_level", int'(level), 0);
        check("t6_dcnt", int'(drop_count), 0);
        reset = 1'b0;
        step(0, 1, 0);
        check("t6_no_evt_after_rst", int'(level), 0);
`ifdef OVF_REPORT_TIMESTAMP_EN
        wrap(0, 0);
        for (int i = 1; i <= 8; i++) step(i, 0, 0);
        wrap(0, 0);
        t1 = int'(evt_ts);
        step(0, 0, 1);
        check("t6_ts_delta", (int'(evt_ts) - t1 + 65536) % 65536, 10);
`else
        t1 = 0;
        wrap(0, 0);
        check("t6_ts_zero", int'(evt_ts), t1);
`endif
        step(0, 0, 1);
        step(0, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
